// File: rtl/ctrl_types_pkg.sv
// CPU control types shared by the load/store path and its responders.
package ctrl_types_pkg;

  typedef enum logic [2:0] {
    MEM_BYTE   = 3'd0,
    MEM_HALF   = 3'd1,
    MEM_WORD   = 3'd2,
    MEM_BYTE_U = 3'd3,
    MEM_HALF_U = 3'd4
  } mem_op_t;

endpackage

// File: rtl/mmio_pkg.sv
// MMIO test-device register map, status layout and lane helpers shared with data_memory.
package mmio_pkg;
  import ctrl_types_pkg::*;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] REG_TOHOST     = 3'd0;
  localparam logic [2:0] REG_CYCLE      = 3'd1;
  localparam logic [2:0] REG_LOG_DATA   = 3'd2;
  localparam logic [2:0] REG_LOG_STATUS = 3'd3;
  localparam logic [2:0] REG_LOG_POP    = 3'd4;
  localparam logic [2:0] REG_SCRATCH    = 3'd5;

  localparam int unsigned ST_EMPTY     = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVERFLOW  = 2;
  localparam int unsigned ST_COUNT_LSB = 8;
  localparam int unsigned ST_COUNT_W   = 8;

  // Pick the addressed lane of a word and sign/zero-extend it for the load size.
  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                   input logic [1:0] boff,
                                                   input mem_op_t op);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] res;
    case (boff)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = boff[1] ? word[31:16] : word[15:0];
    case (op)
      MEM_BYTE:   res = {{24{b[7]}}, b};
      MEM_BYTE_U: res = {24'd0, b};
      MEM_HALF:   res = {{16{h[15]}}, h};
      MEM_HALF_U: res = {16'd0, h};
      default:    res = word;
    endcase
    return res;
  endfunction

  // Merge right-aligned store data into the addressed lane(s) of a word.
  function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] old,
                                                  input logic [XLEN-1:0] data,
                                                  input logic [1:0] boff,
                                                  input mem_op_t op);
    logic [XLEN-1:0] res;
    res = old;
    case (op)
      MEM_BYTE, MEM_BYTE_U: begin
        case (boff)
          2'd0:    res[7:0]   = data[7:0];
          2'd1:    res[15:8]  = data[7:0];
          2'd2:    res[23:16] = data[7:0];
          default: res[31:24] = data[7:0];
        endcase
      end
      MEM_HALF, MEM_HALF_U: begin
        if (boff[1]) res[31:16] = data[15:0];
        else         res[15:0]  = data[15:0];
      end
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head; push when full and pop when empty are dropped.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Memory-mapped test device: halt/exit code, cycle counter, store-log FIFO and scratch word.
module dmem_mmio_responder
  import ctrl_types_pkg::*;
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int unsigned LOG_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  mem_op_t     mem_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        sel,
  output logic        done,
  output logic [30:0] exit_code
);

  localparam int unsigned CNT_W = $clog2(LOG_DEPTH) + 1;

  logic [2:0]       offset;
  logic [1:0]       boff;
  logic             wr;
  logic             word_wr;
  logic             push;
  logic             pop;
  logic [31:0]      cycle;
  logic [31:0]      scratch;
  logic             overflow;
  logic [31:0]      fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [31:0]      status;
  logic [31:0]      rd_word;

  assign sel     = (addr[31:5] == BASE_ADDR[31:5]);
  assign offset  = addr[4:2];
  assign boff    = addr[1:0];
  assign wr      = wr_en && sel;
  assign word_wr = wr && (mem_ctrl == MEM_WORD);
  assign push    = word_wr && (offset == REG_LOG_DATA);
  assign pop     = word_wr && (offset == REG_LOG_POP);

  // First TOHOST word store with bit 0 set latches the halt; later codes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done      <= 1'b0;
      exit_code <= '0;
    end else if (word_wr && (offset == REG_TOHOST) && !done && data_in[0]) begin
      done      <= 1'b1;
      exit_code <= data_in[31:1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cycle <= '0;
    else if (!done) cycle <= cycle + 32'd1;
  end

  // Status writes take priority; push and pop never share a cycle with them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    overflow <= 1'b0;
    else if (word_wr && offset == REG_LOG_STATUS) overflow <= 1'b0;
    else if (push && fifo_full)                   overflow <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           scratch <= '0;
    else if (wr && offset == REG_SCRATCH) scratch <= store_merge(scratch, data_in, boff, mem_ctrl);
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (LOG_DEPTH)
  ) u_log_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (data_in),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status = '0;
    status[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
    status[ST_OVERFLOW] = overflow;
    status[ST_FULL]     = fifo_full;
    status[ST_EMPTY]    = fifo_empty;
  end

  always_comb begin
    rd_word = '0;
    case (offset)
      REG_TOHOST:     rd_word = {exit_code, done};
      REG_CYCLE:      rd_word = cycle;
      REG_LOG_DATA:   rd_word = fifo_empty ? 32'd0 : fifo_head;
      REG_LOG_STATUS: rd_word = status;
      REG_SCRATCH:    rd_word = scratch;
      default:        rd_word = '0;
    endcase
  end

  assign data_out = load_extract(rd_word, boff, mem_ctrl);

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: vector table plus hand-written halt/reset sequences.
module tb_dmem_mmio_responder;
  import ctrl_types_pkg::*;

  localparam logic [31:0] B = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  mem_op_t     mem_ctrl;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        sel;
  logic        done;
  logic [30:0] exit_code;

  int          checks = 0;
  int          errors = 0;
  int unsigned model_cycle = 0;
  logic        model_done = 1'b0;

  typedef struct {
    logic        wr;
    mem_op_t     op;
    logic [31:0] a;
    logic [31:0] d;
    logic        exp_sel;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  dmem_mmio_responder #(
    .BASE_ADDR (32'hFFFF_0000),
    .LOG_DEPTH (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .mem_ctrl  (mem_ctrl),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .sel       (sel),
    .done      (done),
    .exit_code (exit_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: the cycle model advances on every edge out of reset until halted.
  task automatic step();
    @(posedge clk);
    if (!reset && !model_done) model_cycle++;
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input mem_op_t op, input logic [31:0] a, input logic [31:0] d);
    wr_en    = w;
    mem_ctrl = op;
    addr     = a;
    data_in  = d;
  endtask

  task automatic add(input logic w, input mem_op_t op, input logic [31:0] a, input logic [31:0] d,
                     input logic s, input logic c, input logic [31:0] e);
    vec_t v;
    v = '{w, op, a, d, s, c, e};
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, MEM_WORD, B, 32'd0);

    // Store-log FIFO: byte TOHOST store, pop on empty, fill, overflow, drain.
    add(1, MEM_BYTE, B + 32'h00, 32'h01, 1, 0, 0);
    add(0, MEM_WORD, B + 32'h00, 0, 1, 1, 32'h0);
    add(1, MEM_WORD, B + 32'h10, 0, 1, 0, 0);
    add(0, MEM_WORD, B + 32'h0C, 0, 1, 1, 32'h0000_0001);
    for (int k = 1; k <= 9; k++) add(1, MEM_WORD, B + 32'h08, 32'(k), 1, 0, 0);
    add(0, MEM_WORD,   B + 32'h0C, 0, 1, 1, 32'h0000_0806);
    add(0, MEM_BYTE_U, B + 32'h0D, 0, 1, 1, 32'h0000_0008);
    add(0, MEM_BYTE,   B + 32'h0C, 0, 1, 1, 32'h0000_0006);
    for (int k = 1; k <= 8; k++) begin
      add(0, MEM_WORD, B + 32'h08, 0, 1, 1, 32'(k));
      add(1, MEM_WORD, B + 32'h10, 0, 1, 0, 0);
    end
    add(0, MEM_WORD, B + 32'h0C, 0, 1, 1, 32'h0000_0005);
    add(1, MEM_WORD, B + 32'h0C, 0, 1, 0, 0);
    add(0, MEM_WORD, B + 32'h0C, 0, 1, 1, 32'h0000_0001);
    add(0, MEM_WORD, B + 32'h08, 0, 1, 1, 32'h0);
    add(0, MEM_WORD, B + 32'h10, 0, 1, 1, 32'h0);
    // SCRATCH lanes.
    add(1, MEM_WORD,   B + 32'h14, 32'h1234_80F0, 1, 0, 0);
    add(1, MEM_BYTE,   B + 32'h15, 32'h0000_00AA, 1, 0, 0);
    add(0, MEM_WORD,   B + 32'h14, 0, 1, 1, 32'h1234_AAF0);
    add(0, MEM_BYTE,   B + 32'h15, 0, 1, 1, 32'hFFFF_FFAA);
    add(0, MEM_BYTE_U, B + 32'h15, 0, 1, 1, 32'h0000_00AA);
    add(0, MEM_HALF,   B + 32'h16, 0, 1, 1, 32'h0000_1234);
    add(0, MEM_HALF,   B + 32'h14, 0, 1, 1, 32'hFFFF_AAF0);
    add(0, MEM_HALF_U, B + 32'h14, 0, 1, 1, 32'h0000_AAF0);
    add(1, MEM_HALF,   B + 32'h17, 32'h0000_BEEF, 1, 0, 0);
    add(0, MEM_WORD,   B + 32'h14, 0, 1, 1, 32'hBEEF_AAF0);
    // Sub-word store to a non-SCRATCH register is ignored.
    add(1, MEM_BYTE, B + 32'h08, 32'h33, 1, 0, 0);
    add(0, MEM_WORD, B + 32'h0C, 0, 1, 1, 32'h0000_0001);
    // Outside the window: no decode, no state change.
    add(1, MEM_WORD, B - 32'h04, 32'h1, 0, 0, 0);
    add(1, MEM_WORD, B + 32'h20, 32'h1, 0, 0, 0);
    add(1, MEM_WORD, B + 32'h28, 32'h77, 0, 0, 0);
    add(1, MEM_WORD, B + 32'h34, 32'hDEAD_0000, 0, 0, 0);
    add(0, MEM_WORD, B + 32'h0C, 0, 1, 1, 32'h0000_0001);
    add(0, MEM_WORD, B + 32'h14, 0, 1, 1, 32'hBEEF_AAF0);
    add(1, MEM_WORD, B + 32'h1C, 32'hFFFF_FFFF, 1, 0, 0);
    add(0, MEM_WORD, B + 32'h1C, 0, 1, 1, 32'h0);
    add(0, MEM_WORD, B + 32'h18, 0, 1, 1, 32'h0);

    // Reset state, then release and count 20 edges.
    @(negedge clk);
    #1;
    check("rst done", 32'(done), 32'd0);
    check("rst exit_code", 32'(exit_code), 32'd0);
    check("rst tohost", data_out, 32'd0);
    drive(1'b0, MEM_WORD, B + 32'h0C, 32'd0);
    #1 check("rst status", data_out, 32'h0000_0001);
    @(negedge clk);
    reset = 1'b0;
    model_cycle = 0;
    drive(1'b0, MEM_WORD, B + 32'h04, 32'd0);
    #1 check("cycle0", data_out, 32'd0);
    for (int i = 0; i < 20; i++) step();
    #1 check("cycle20", data_out, 32'd20);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wr, vecs[i].op, vecs[i].a, vecs[i].d);
      #1;
      check($sformatf("vec%0d sel", i), 32'(sel), 32'(vecs[i].exp_sel));
      if (vecs[i].chk) check($sformatf("vec%0d data_out", i), data_out, vecs[i].exp);
      check($sformatf("vec%0d done", i), 32'(done), 32'd0);
      step();
    end

    // Halt via TOHOST: code 0x2A kept, counter frozen.
    drive(1'b1, MEM_WORD, B, 32'h0000_0055);
    step();
    model_done = 1'b1;
    drive(1'b0, MEM_WORD, B + 32'h04, 32'd0);
    #1;
    check("halt done", 32'(done), 32'd1);
    check("halt exit_code", 32'(exit_code), 32'h2A);
    check("halt cycle", data_out, model_cycle);
    drive(1'b1, MEM_WORD, B, 32'h0000_0007);
    step();
    step();
    step();
    drive(1'b0, MEM_WORD, B + 32'h04, 32'd0);
    #1 check("frozen cycle", data_out, model_cycle);
    check("second code exit_code", 32'(exit_code), 32'h2A);
    drive(1'b0, MEM_WORD, B, 32'd0);
    #1 check("tohost read", data_out, 32'h0000_0055);

    // Leave state behind, then reset mid-run between clock edges.
    drive(1'b1, MEM_WORD, B + 32'h08, 32'h0000_00AB);
    step();
    drive(1'b1, MEM_WORD, B + 32'h14, 32'h0000_0011);
    step();
    drive(1'b0, MEM_WORD, B + 32'h0C, 32'd0);
    #1 check("pre-reset status", data_out, 32'h0000_0100);
    #2 reset = 1'b1;
    #1 check("midrst status", data_out, 32'h0000_0001);
    check("midrst done", 32'(done), 32'd0);
    check("midrst exit_code", 32'(exit_code), 32'd0);
    drive(1'b0, MEM_WORD, B + 32'h04, 32'd0);
    #1 check("midrst cycle", data_out, 32'd0);
    drive(1'b0, MEM_WORD, B + 32'h14, 32'd0);
    #1 check("midrst scratch", data_out, 32'd0);
    drive(1'b0, MEM_WORD, B + 32'h08, 32'd0);
    #1 check("midrst head", data_out, 32'd0);
    drive(1'b0, MEM_WORD, B + 32'h04, 32'd0);
    step();
    #1 check("held reset cycle", data_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_cycle = 0;
    model_done = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #1 check("post-reset cycle", data_out, model_cycle);
    check("post-reset done", 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
